prog_loader: RTL

- Boot/reload sequencer for the processor.
- Holds the core in reset while it streams a program image from a host word stream (valid/ready) into the instruction memory and then the data memory.
- Checks an XOR checksum over the streamed words, then releases the core after a programmable reset-hold time.
- Sits between a host link (UART/JTAG bridge) and the write ports of the instruction and data memories, plus the core reset.

---
 rtl/prog_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot/reload sequencer streaming a program image into instruction and data memories
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start, n_instr, n_data load request and word counts (sampled on an accepted start)
//   s_valid, s_data, s_ready  host word stream
//   im_wr, im_addr, im_data   instruction memory write port
//   dm_wr, dm_addr, dm_data   data memory write port
//   core_hold              1 = core held in reset
//   busy, done, err        load in progress, release pulse after a load, sticky load error
module prog_loader #(
    parameter int NBINST = 14,
    parameter int NUBITS = 16,
    parameter int NBWORD = 16,
    parameter int MINSTS = 64,
    parameter int MDATAS = 64,
    parameter int MINSTW = $clog2(MINSTS),
    parameter int MDATAW = $clog2(MDATAS),
    parameter int RSTHLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MINSTW:0]   n_instr,
    input  logic [MDATAW:0]   n_data,
    input  logic              s_valid,
    input  logic [NBWORD-1:0] s_data,
    output logic              s_ready,
    output logic              im_wr,
    output logic [MINSTW-1:0] im_addr,
    output logic [NBINST-1:0] im_data,
    output logic              dm_wr,
    output logic [MDATAW-1:0] dm_addr,
    output logic [NUBITS-1:0] dm_data,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HW = $clog2(RSTHLD + 1);

    typedef enum logic [2:0] {HOLD, RUN, LD_I, LD_D, CHK, ERR} state_t;

    state_t            state, state_n;
    logic [MINSTW:0]   ni_q, i_cnt;
    logic [MDATAW:0]   nd_q, d_cnt;
    logic [NBWORD-1:0] csum;
    logic [HW-1:0]     hold_cnt;
    logic              from_chk;

    logic accept, can_start, counts_ok, start_ok, last_i, last_d, hold_end;

    assign accept    = s_valid && s_ready;
    assign can_start = (state == RUN) || (state == ERR);
    assign counts_ok = (32'(n_instr) <= MINSTS) && (32'(n_data) <= MDATAS);
    assign start_ok  = can_start && start && counts_ok;
    assign last_i    = (i_cnt == ni_q - 1'b1);
    assign last_d    = (d_cnt == nd_q - 1'b1);
    assign hold_end  = (32'(hold_cnt) == RSTHLD - 1);

    always_comb begin
        state_n = state;
        case (state)
            HOLD: if (hold_end) state_n = RUN;
            RUN, ERR: begin
                if (start) begin
                    if (!counts_ok)        state_n = ERR;
                    else if (n_instr != 0) state_n = LD_I;
                    else if (n_data != 0)  state_n = LD_D;
                    else                   state_n = CHK;
                end
            end
            LD_I: if (accept && last_i) state_n = (nd_q != 0) ? LD_D : CHK;
            LD_D: if (accept && last_d) state_n = CHK;
            CHK:  if (accept) state_n = (s_data == csum) ? HOLD : ERR;
            default: state_n = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HOLD;
        else      state <= state_n;
    end

    // Status outputs are registered copies of the next state, so they always
    // line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            core_hold <= 1'b1;
            err       <= 1'b0;
            done      <= 1'b0;
            im_wr     <= 1'b0;
            im_addr   <= '0;
            im_data   <= '0;
            dm_wr     <= 1'b0;
            dm_addr   <= '0;
            dm_data   <= '0;
            ni_q      <= '0;
            nd_q      <= '0;
            i_cnt     <= '0;
            d_cnt     <= '0;
            csum      <= '0;
            hold_cnt  <= '0;
            from_chk  <= 1'b0;
        end else begin
            s_ready   <= (state_n == LD_I) || (state_n == LD_D) || (state_n == CHK);
            busy      <= (state_n == LD_I) || (state_n == LD_D) || (state_n == CHK);
            core_hold <= (state_n != RUN);
            err       <= (state_n == ERR);
            done      <= (state == HOLD) && hold_end && from_chk;
            im_wr     <= (state == LD_I) && accept;
            dm_wr     <= (state == LD_D) && accept;

            // Counter restarts on every HOLD entry because it is cleared outside HOLD.
            if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
            else               hold_cnt <= '0;

            if (state == CHK && state_n == HOLD)   from_chk <= 1'b1;
            else if (state == HOLD && hold_end)    from_chk <= 1'b0;

            if (start_ok) begin
                ni_q  <= n_instr;
                nd_q  <= n_data;
                i_cnt <= '0;
                d_cnt <= '0;
                csum  <= '0;
            end

            if (state == LD_I && accept) begin
                im_addr <= i_cnt[MINSTW-1:0];
                im_data <= s_data[NBINST-1:0];
                i_cnt   <= i_cnt + 1'b1;
                csum    <= csum ^ s_data;
            end

            if (state == LD_D && accept) begin
                dm_addr <= d_cnt[MDATAW-1:0];
                dm_data <= s_data[NUBITS-1:0];
                d_cnt   <= d_cnt + 1'b1;
                csum    <= csum ^ s_data;
            end
        end
    end

endmodule
